// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg
//   Shared Q8.8 constants, the controller state encoding and a midpoint
//   helper for the inverse-sigmoid search and its lookup sub-module.
//   No ports (package).
package sigmoid_pkg;

  // Q8.8 fixed point: 8 integer bits, 8 fraction bits, two's complement.
  localparam logic signed [15:0] Q_ONE = 16'sh0100;
  localparam logic signed [15:0] X_MIN = -16'sd2048;
  localparam logic signed [15:0] X_MAX = 16'sd2048;
  localparam int                 ITER  = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Floor midpoint of two Q8.8 values. The sum is formed on 17 bits so
  // lo + hi cannot wrap before the arithmetic shift.
  function automatic logic signed [15:0] q_mid(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [16:0] s;
    s = $signed({a[15], a}) + $signed({b[15], b});
    return 16'(s >>> 1);
  endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// sigmoid_lut
//   Combinational Q8.8 sigmoid. Piecewise-linear segment table evaluated on
//   |x| and mirrored for negative inputs (sigmoid(-x) = 1 - sigmoid(x)).
//   The result is monotonic non-decreasing over the whole input range and
//   never reaches Q_ONE, so the top of the search window stays below 1.0.
//   Ports:
//     in_val  - Q8.8 signed argument x
//     out_val - Q8.8 signed sigmoid(x), range 0x0001..0x00FF
module sigmoid_lut
  import sigmoid_pkg::*;
(
  input  logic signed [15:0] in_val,
  output logic signed [15:0] out_val
);

  localparam logic [16:0] ONE17  = 17'(Q_ONE);
  localparam logic [16:0] SAT_HI = ONE17 - 17'd1;

  // Segment table on |x| (Q8.8):
  //   |x| in [0, 1.0)      : 0.25    * |x| + 0.5      (rounded up)
  //   |x| in [1.0, 2.375)  : 0.125   * |x| + 0.625
  //   |x| in [2.375, 5.0)  : 0.03125 * |x| + 0.84375
  //   |x| >= 5.0           : 255/256
  localparam logic [16:0] SEG1_X = 17'd256;
  localparam logic [16:0] SEG2_X = 17'd608;
  localparam logic [16:0] SEG3_X = 17'd1280;

  logic        neg;
  logic [16:0] mag;
  logic [16:0] seg;

  always_comb begin
    neg = in_val[15];
    // 17-bit magnitude so that -32768 has a representable absolute value.
    mag = neg ? (17'd0 - {in_val[15], in_val}) : {1'b0, in_val};
    if (mag >= SEG3_X) begin
      seg = SAT_HI;
    end else if (mag >= SEG2_X) begin
      seg = (mag >> 5) + 17'd216;
    end else if (mag >= SEG1_X) begin
      seg = (mag >> 3) + 17'd160;
    end else begin
      // Rounding up keeps sigmoid(-1 LSB) strictly below 0.5, so the
      // smallest x with sigmoid(x) >= 0.5 is exactly 0.
      seg = ((mag + 17'd3) >> 2) + 17'd128;
    end
    out_val = neg ? 16'(ONE17 - seg) : 16'(seg);
  end

endmodule

// File: rtl/sigmoid_inverse.sv
// sigmoid_inverse
//   Binary search for the smallest x in [X_MIN, X_MAX] with
//   sigmoid(x) >= p, one iteration per clock, valid/ready on both sides.
//   Returns X_MAX when no such x exists.
//   Ports:
//     clk       - clock, rising edge
//     rst_n     - asynchronous active-low reset
//     in_valid  - request present, in_p valid
//     in_ready  - block accepts a request (IDLE only)
//     in_p      - Q8.8 target probability
//     out_valid - result present (DONE only)
//     out_ready - consumer takes the result
//     out_x     - Q8.8 result
//     out_sat   - out_x sits on X_MIN or X_MAX
//
//   state  | meaning
//   IDLE   | waiting for in_valid; in_ready high (from first edge after reset)
//   SEARCH | ITER bisection steps, then one cycle to publish lo
//   DONE   | holding out_x/out_sat until out_ready
module sigmoid_inverse #(
  parameter int                 ITER  = sigmoid_pkg::ITER,
  parameter logic signed [15:0] X_MIN = sigmoid_pkg::X_MIN,
  parameter logic signed [15:0] X_MAX = sigmoid_pkg::X_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_x,
  output logic               out_sat
);

  import sigmoid_pkg::*;

  localparam int                CNT_W    = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER);

  state_e             state;
  state_e             state_nx;
  logic signed [15:0] p;
  logic signed [15:0] lo;
  logic signed [15:0] hi;
  logic signed [15:0] mid;
  logic signed [15:0] sig_mid;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               step;
  logic               finish;

  assign mid = q_mid(lo, hi);

  sigmoid_lut u_lut (
    .in_val  (mid),
    .out_val (sig_mid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready is gated through accept so nothing is taken before the first
  // edge after reset release.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept   = 1'b1;
          state_nx = SEARCH;
        end
      end
      SEARCH: begin
        if (cnt == CNT_LAST) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so both read 0
  // during reset and in_ready comes up on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      lo      <= '0;
      hi      <= '0;
      cnt     <= '0;
      out_x   <= '0;
      out_sat <= 1'b0;
    end else begin
      if (accept) begin
        p   <= in_p;
        lo  <= X_MIN;
        hi  <= X_MAX;
        cnt <= '0;
      end else if (step) begin
        // Once the window has collapsed the remaining steps are no-ops.
        if (lo < hi) begin
          if (sig_mid >= p) begin
            hi <= mid;
          end else begin
            lo <= mid + 16'sd1;
          end
        end
        cnt <= cnt + CNT_W'(1);
      end else if (finish) begin
        out_x   <= lo;
        out_sat <= (lo == X_MIN) || (lo == X_MAX);
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_inverse.sv
// tb_sigmoid_inverse
//   Directed checks of sigmoid_inverse: lookup points, reset values,
//   midpoint latency, saturation, round trips, back-pressure, reset during
//   search and a random sweep against a linear scan of the lookup.
module tb_sigmoid_inverse;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_p;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_x;
  logic               out_sat;

  logic signed [15:0] lut_x;
  logic signed [15:0] lut_y;
  logic signed [15:0] sig_tab [0:4096];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sigmoid_inverse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_sat   (out_sat)
  );

  sigmoid_lut u_ref (
    .in_val  (lut_x),
    .out_val (lut_y)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] tab(input logic signed [15:0] x);
    return sig_tab[int'(x) + 2048];
  endfunction

  // Smallest x in [-2048, 2048] whose lookup value reaches pv, else 2048.
  function automatic logic signed [15:0] model_x(input logic signed [15:0] pv);
    for (int i = 0; i <= 4096; i++) begin
      if (sig_tab[i] >= pv) return 16'(i - 2048);
    end
    return 16'sd2048;
  endfunction

  task automatic lut_chk(input string tag, input logic signed [15:0] x,
                         input logic [15:0] exp);
    lut_x = x;
    #1;
    chk(tag, lut_y, exp);
  endtask

  // One full request: wait for in_ready, present pv, count edges to
  // out_valid, hold the result for 'hold' cycles, then handshake.
  task automatic do_req(input logic signed [15:0] pv, input int hold,
                        output logic signed [15:0] xo, output logic so,
                        output int lat);
    int  w;
    logic moved;
    w     = 0;
    lat   = 0;
    moved = 1'b0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    in_p     = pv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_p     = 16'shA5A5;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", 16'(out_valid), 16'd1);
    xo = out_x;
    so = out_sat;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (out_x !== xo || out_sat !== so || out_valid !== 1'b1) moved = 1'b1;
    end
    if (hold > 0) chk("hold_stable", 16'(moved), 16'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic signed [15:0] xo;
    logic signed [15:0] pv;
    logic signed [15:0] rt_x   [3];
    logic signed [15:0] rt_exp [3];
    logic               so;
    logic               moved;
    logic               busy;
    int                 lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_p      = 16'sh0000;
    out_ready = 1'b0;
    lut_x     = 16'sh0000;

    lut_chk("lut_0",     16'sd0,     16'h0080);
    lut_chk("lut_m1",    -16'sd1,    16'h007F);
    lut_chk("lut_p1",    16'sd1,     16'h0081);
    lut_chk("lut_m256",  -16'sd256,  16'h0040);
    lut_chk("lut_p256",  16'sd256,   16'h00C0);
    lut_chk("lut_p896",  16'sd896,   16'h00F4);
    lut_chk("lut_p1247", 16'sd1247,  16'h00FE);
    lut_chk("lut_p1248", 16'sd1248,  16'h00FF);
    lut_chk("lut_max",   16'sd2048,  16'h00FF);
    lut_chk("lut_min",   -16'sd2048, 16'h0001);

    for (int i = 0; i <= 4096; i++) begin
      lut_x = 16'(i - 2048);
      #1;
      sig_tab[i] = lut_y;
    end

    chk("rst_in_ready",  16'(in_ready),  16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_x",     out_x,          16'h0000);
    chk("rst_out_sat",   16'(out_sat),   16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 16'(in_ready), 16'd1);

    // midpoint
    do_req(16'sh0080, 0, xo, so, lat);
    chk("mid_x",   xo,       16'h0000);
    chk("mid_sat", 16'(so),  16'd0);
    chk("mid_lat", 16'(lat), 16'd14);
    chk("mid_ready_next", 16'(in_ready), 16'd1);

    // saturation and the top edge of the lookup
    do_req(16'sh0000, 0, xo, so, lat);
    chk("sat0_x", xo, 16'hF800);
    chk("sat0_s", 16'(so), 16'd1);
    do_req(16'sh0100, 0, xo, so, lat);
    chk("sat1_x", xo, 16'h0800);
    chk("sat1_s", 16'(so), 16'd1);
    do_req(16'sh8000, 0, xo, so, lat);
    chk("satneg_x", xo, 16'hF800);
    chk("satneg_s", 16'(so), 16'd1);
    do_req(16'sh0001, 0, xo, so, lat);
    chk("satlo_x", xo, 16'hF800);
    chk("satlo_s", 16'(so), 16'd1);
    do_req(16'sh00FF, 0, xo, so, lat);
    chk("top_x", xo, 16'h04E0);
    chk("top_s", 16'(so), 16'd0);

    // round trips
    rt_x[0] = -16'sh0100; rt_exp[0] = 16'shFEF9;
    rt_x[1] = 16'sh0100;  rt_exp[1] = 16'sh00FD;
    rt_x[2] = 16'sh0380;  rt_exp[2] = 16'sh0380;
    for (int i = 0; i < 3; i++) begin
      pv = tab(rt_x[i]);
      do_req(pv, 0, xo, so, lat);
      chk("rt_exact", xo, rt_exp[i]);
      chk("rt_le",    16'(xo <= rt_x[i]), 16'd1);
      chk("rt_hit",   tab(xo), pv);
      chk("rt_below", 16'(tab(xo - 16'sd1) < pv), 16'd1);
    end

    // back-pressure with a second request presented while DONE
    @(negedge clk);
    in_valid = 1'b1;
    in_p     = 16'sh00C0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_done", 16'(out_valid), 16'd1);
    xo    = out_x;
    moved = 1'b0;
    busy  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = (k >= 5 && k < 10);
      in_p     = 16'sh0000;
      @(posedge clk);
      #1;
      if (out_x !== xo || out_valid !== 1'b1) moved = 1'b1;
      if (in_ready !== 1'b0) busy = 1'b1;
    end
    chk("bp_x",      xo,           16'h00FD);
    chk("bp_stable", 16'(moved),   16'd0);
    chk("bp_ready0", 16'(busy),    16'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_hs_valid", 16'(out_valid), 16'd0);
    chk("bp_hs_ready", 16'(in_ready),  16'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_noqueue_ready", 16'(in_ready),  16'd1);
    chk("bp_noqueue_valid", 16'(out_valid), 16'd0);

    // reset during search
    @(negedge clk);
    in_valid = 1'b1;
    in_p     = 16'sh00F0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mr_busy", 16'(in_ready), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 16'(out_valid), 16'd0);
    chk("mr_ready", 16'(in_ready),  16'd0);
    chk("mr_x",     out_x,          16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_ready_up", 16'(in_ready),  16'd1);
    chk("mr_no_stale", 16'(out_valid), 16'd0);
    do_req(16'sh0080, 0, xo, so, lat);
    chk("mr_fresh_x",   xo,       16'h0000);
    chk("mr_fresh_lat", 16'(lat), 16'd14);

    // random sweep
    for (int n = 0; n < 500; n++) begin
      pv = 16'($urandom_range(0, 256));
      do_req(pv, int'($urandom_range(0, 3)), xo, so, lat);
      chk("sweep_x", xo, model_x(pv));
      chk("sweep_sat", 16'(so), 16'(model_x(pv) == -16'sd2048 || model_x(pv) == 16'sd2048));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
